// File: rtl/demux_striping_pkg.sv
// Shared constants for the two-lane striping link.
// WIDTH_DEF   : word width carried on the serial stream and on each lane.
// STRETCH_DEF : clk_2f cycles per clk_f period, which is how long a lane
//               valid stays high after each load.
package demux_striping_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int STRETCH_DEF = 2;

    // The counter holds values 0..STRETCH-1, and it needs at least one bit.
    function automatic int stretch_cnt_w(input int stretch);
        return (stretch > 1) ? $clog2(stretch) : 1;
    endfunction

endpackage

// File: rtl/demux_striping_if.sv
// Bus between the serial word source and the two lane outputs of the
// striping demux.
//   data_in / valid_in       : serial word stream (clk_2f domain)
//   data_out0 / valid_out0   : lane 0, which carries the even word of a pair
//   data_out1 / valid_out1   : lane 1, which carries the odd word of a pair
// Modport slave is the demux side. Modport master is the source/sink side.
interface demux_striping_if
    import demux_striping_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_out0;
    logic             valid_out0;
    logic [WIDTH-1:0] data_out1;
    logic             valid_out1;

    modport slave (
        input  data_in, valid_in,
        output data_out0, valid_out0, data_out1, valid_out1
    );

    modport master (
        output data_in, valid_in,
        input  data_out0, valid_out0, data_out1, valid_out1
    );
endinterface

// File: rtl/demux_striping.sv
// Striping side of the two-lane link. The block deals consecutive valid
// words on clk_2f alternately to lane 0 and lane 1. When a pair completes,
// both lanes load at the same time and keep valid high for STRETCH cycles.
// If the stream gaps after the first word of a pair, that word is flushed
// alone on lane 0.
// Ports:
//   clk_2f  : clock for all state, rising edge
//   reset_L : asynchronous active-low reset
//   bus     : demux_striping_if.slave (input stream plus two registered lanes)
module demux_striping
    import demux_striping_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int STRETCH = STRETCH_DEF
)(
    input  logic             clk_2f,
    input  logic             reset_L,
    demux_striping_if.slave  bus
);

    localparam int CNT_W = stretch_cnt_w(STRETCH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH - 1);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             sel_q, sel_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_out0_q, data_out0_d;
    logic [WIDTH-1:0] data_out1_q, data_out1_d;
    logic             valid_out0_q, valid_out0_d;
    logic             valid_out1_q, valid_out1_d;

    logic load_pair;
    logic load_flush;

    // A flush can only happen when valid_in is low. So these two loads
    // are mutually exclusive.
    assign load_pair  = bus.valid_in & sel_q;
    assign load_flush = ~bus.valid_in & pending_q;

    always_comb begin
        hold_d       = hold_q;
        sel_d        = sel_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        data_out0_d  = data_out0_q;
        data_out1_d  = data_out1_q;
        valid_out0_d = valid_out0_q;
        valid_out1_d = valid_out1_q;

        if (load_pair) begin
            data_out0_d  = hold_q;
            data_out1_d  = bus.data_in;
            valid_out0_d = 1'b1;
            valid_out1_d = 1'b1;
            cnt_d        = CNT_LOAD;
            pending_d    = 1'b0;
            sel_d        = 1'b0;
        end else if (load_flush) begin
            // A lone word goes out on lane 0. Lane 1 keeps its stale data
            // but stays invalid.
            data_out0_d  = hold_q;
            valid_out0_d = 1'b1;
            valid_out1_d = 1'b0;
            cnt_d        = CNT_LOAD;
            pending_d    = 1'b0;
            sel_d        = 1'b0;
        end else begin
            if (cnt_q == '0) begin
                valid_out0_d = 1'b0;
                valid_out1_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            // The first word of a pair only parks in hold. The lanes keep
            // showing the previous pair until it finishes stretching.
            if (bus.valid_in) begin
                hold_d    = bus.data_in;
                pending_d = 1'b1;
                sel_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            hold_q       <= '0;
            sel_q        <= 1'b0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            data_out0_q  <= '0;
            data_out1_q  <= '0;
            valid_out0_q <= 1'b0;
            valid_out1_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            sel_q        <= sel_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            data_out0_q  <= data_out0_d;
            data_out1_q  <= data_out1_d;
            valid_out0_q <= valid_out0_d;
            valid_out1_q <= valid_out1_d;
        end
    end

    assign bus.data_out0  = data_out0_q;
    assign bus.data_out1  = data_out1_q;
    assign bus.valid_out0 = valid_out0_q;
    assign bus.valid_out1 = valid_out1_q;

endmodule
